// File: rtl/hex_display_pkg.sv
// Shared types, segment width and the active-high hex decode table for hex_display_bank.
// Segment width depends on the HEX_DP_EN macro (8 with decimal point, 7 without).
package hex_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHOW   = 2'd2,
        SCROLL = 2'd3
    } state_t;

`ifdef HEX_DP_EN
    localparam int SEG = 8;
`else
    localparam int SEG = 7;
`endif

    // Dark digit patterns for active-low and active-high pin wiring.
    localparam logic [SEG-1:0] SEG_OFF_LOW  = '1;
    localparam logic [SEG-1:0] SEG_OFF_HIGH = '0;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_display_tick.sv
// hex_tick_gen: modulo-DIV counter emitting a one-cycle tick every DIV cycles.
// The clear input holds the count at zero and suppresses the tick.
module hex_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear || (count_reg == LAST)) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign tick = !clear && (count_reg == LAST);

endmodule

// File: rtl/hex_display_bank.sv
// Bank of NUM_DIGITS seven-segment drivers with blank/blink masks and circular scroll.
// Define HEX_DP_EN to add a position-fixed decimal point per digit (wr_dp_mask).
module hex_display_bank
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_HZ     = 50_000_000,
    parameter int BLINK_HZ   = 2,
    parameter int SCROLL_HZ  = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [4*NUM_DIGITS-1:0]     wr_data,
    input  logic [NUM_DIGITS-1:0]       wr_blank_mask,
    input  logic [NUM_DIGITS-1:0]       wr_blink_mask,
`ifdef HEX_DP_EN
    input  logic [NUM_DIGITS-1:0]       wr_dp_mask,
`endif
    input  logic                        wr_scroll,
    output logic [SEG*NUM_DIGITS-1:0]   hex_out,
    output logic                        scroll_wrap
);

    localparam int BLINK_DIV  = CLK_HZ / (2 * BLINK_HZ);
    localparam int SCROLL_DIV = CLK_HZ / SCROLL_HZ;
    localparam int OFF_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [OFF_W-1:0]          LAST_OFF = OFF_W'(NUM_DIGITS - 1);
    localparam logic [SEG-1:0]            SEG_OFF  = (ACTIVE_LOW != 0) ? SEG_OFF_LOW : SEG_OFF_HIGH;
    localparam logic [SEG*NUM_DIGITS-1:0] ALL_OFF  = {NUM_DIGITS{SEG_OFF}};

    state_t                      state_reg;
    logic                        ready_reg;
    logic [4*NUM_DIGITS-1:0]     data_reg;
    logic [NUM_DIGITS-1:0]       blank_reg;
    logic [NUM_DIGITS-1:0]       blink_reg;
    logic                        scroll_mode_reg;
    logic [OFF_W-1:0]            offset_reg;
    logic [OFF_W-1:0]            offset_next;
    logic                        wrap_reg;
    logic                        phase_on_reg;
    logic [SEG*NUM_DIGITS-1:0]   hex_reg;
    logic [SEG*NUM_DIGITS-1:0]   seg_on;
    logic                        accept;
    logic                        blink_tick;
    logic                        scroll_tick;
    logic                        scroll_clear;
`ifdef HEX_DP_EN
    logic [NUM_DIGITS-1:0]       dp_reg;
`endif

    assign accept       = wr_valid && ready_reg;
    // A new write restarts the scroll period, so a coinciding tick is dropped.
    assign scroll_clear = accept || (state_reg != SCROLL);
    assign offset_next  = (offset_reg == LAST_OFF) ? '0 : offset_reg + OFF_W'(1);

    hex_tick_gen #(
        .DIV (BLINK_DIV)
    ) u_blink_tick (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .clear (1'b0),
        .tick  (blink_tick)
    );

    hex_tick_gen #(
        .DIV (SCROLL_DIV)
    ) u_scroll_tick (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .clear (scroll_clear),
        .tick  (scroll_tick)
    );

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg       <= IDLE;
            ready_reg       <= 1'b1;
            data_reg        <= '0;
            blank_reg       <= '0;
            blink_reg       <= '0;
            scroll_mode_reg <= 1'b0;
            offset_reg      <= '0;
            wrap_reg        <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;
            if (accept) begin
                state_reg       <= LOAD;
                ready_reg       <= 1'b0;
                data_reg        <= wr_data;
                blank_reg       <= wr_blank_mask;
                blink_reg       <= wr_blink_mask;
                scroll_mode_reg <= wr_scroll;
                offset_reg      <= '0;
            end else begin
                case (state_reg)
                    LOAD: begin
                        state_reg <= scroll_mode_reg ? SCROLL : SHOW;
                        ready_reg <= 1'b1;
                    end
                    SCROLL: begin
                        if (scroll_tick) begin
                            offset_reg <= offset_next;
                            wrap_reg   <= (offset_next == '0);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef HEX_DP_EN
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            dp_reg <= '0;
        end else if (accept) begin
            dp_reg <= wr_dp_mask;
        end
    end
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            phase_on_reg <= 1'b1;
        end else if (blink_tick) begin
            phase_on_reg <= !phase_on_reg;
        end
    end

    logic [3:0] nib_arr [NUM_DIGITS];

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        localparam logic [OFF_W:0] POS  = (OFF_W + 1)'(gi);
        localparam logic [OFF_W:0] WRAP = (OFF_W + 1)'(gi + NUM_DIGITS);

        logic [OFF_W:0]   off_ext;
        logic [OFF_W-1:0] src_idx;
        logic             dark;
        logic [6:0]       seg7;

        assign nib_arr[gi] = data_reg[4*gi +: 4];

        // Physical digit gi shows stored nibble (gi - offset) mod NUM_DIGITS.
        assign off_ext = {1'b0, offset_reg};
        assign src_idx = (off_ext <= POS) ? OFF_W'(POS - off_ext) : OFF_W'(WRAP - off_ext);

        assign dark = blank_reg[gi] || (blink_reg[gi] && !phase_on_reg);
        assign seg7 = dark ? 7'h00 : seg7_decode(nib_arr[src_idx]);

`ifdef HEX_DP_EN
        assign seg_on[SEG*gi +: SEG] = {dp_reg[gi] && !dark, seg7};
`else
        assign seg_on[SEG*gi +: SEG] = seg7;
`endif
    end

    // LOAD keeps the previous picture so new content appears one cycle later.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            hex_reg <= ALL_OFF;
        end else if (state_reg == IDLE) begin
            hex_reg <= ALL_OFF;
        end else if (state_reg != LOAD) begin
            hex_reg <= (ACTIVE_LOW != 0) ? ~seg_on : seg_on;
        end
    end

    assign wr_ready    = ready_reg;
    assign hex_out     = hex_reg;
    assign scroll_wrap = wrap_reg;

endmodule

// File: tb/tb_hex_display_bank.sv
// Self-checking bench for hex_display_bank with a cycle-indexed behavioural model.
// Also builds with HEX_DP_EN defined (decimal point per digit).
module tb_hex_display_bank;

`ifdef HEX_DP_EN
    localparam int SEG = 8;
`else
    localparam int SEG = 7;
`endif
    localparam int ND = 6;
    localparam int HW = SEG * ND;

    logic          clk_clk       = 1'b0;
    logic          reset_reset   = 1'b0;
    logic          wr_valid      = 1'b0;
    logic          wr_ready;
    logic [23:0]   wr_data       = '0;
    logic [5:0]    wr_blank_mask = '0;
    logic [5:0]    wr_blink_mask = '0;
    logic [5:0]    wr_dp_mask    = '0;
    logic          wr_scroll     = 1'b0;
    logic [HW-1:0] hex_out;
    logic          scroll_wrap;

    int checks    = 0;
    int errors    = 0;
    int k         = 0;   // clock edges since reset release
    int wrap_seen = 0;

    typedef struct {
        bit          valid;
        int          acc;
        logic [23:0] data;
        logic [5:0]  blank;
        logic [5:0]  blink;
        logic [5:0]  dp;
        bit          scroll;
    } rec_t;

    rec_t cur;
    rec_t prev;

    hex_display_bank #(
        .NUM_DIGITS (6),
        .CLK_HZ     (16),
        .BLINK_HZ   (1),
        .SCROLL_HZ  (2),
        .ACTIVE_LOW (1)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset   (reset_reset),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .wr_blank_mask (wr_blank_mask),
        .wr_blink_mask (wr_blink_mask),
`ifdef HEX_DP_EN
        .wr_dp_mask    (wr_dp_mask),
`endif
        .wr_scroll     (wr_scroll),
        .hex_out       (hex_out),
        .scroll_wrap   (scroll_wrap)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] tab [16];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tab[n];
    endfunction

    function automatic bit exp_ready();
        return !(cur.valid && (k == cur.acc));
    endfunction

    // Picture after edge kq: new content from acc+2, before that the old picture as of acc.
    function automatic logic [HW-1:0] exp_hex(input int kq);
        rec_t          r;
        int            kk;
        int            off;
        bit            ph_off;
        logic [HW-1:0] v;
        v = '1;
        if (!cur.valid) return v;
        if (kq >= cur.acc + 2) begin
            r  = cur;
            kk = kq;
        end else begin
            r  = prev;
            kk = cur.acc;
        end
        if (!r.valid) return v;
        off    = r.scroll ? ((kk - r.acc - 2) / 8) % ND : 0;
        ph_off = (((kk - 1) / 8) % 2) == 1;
        for (int i = 0; i < ND; i++) begin
            int         src;
            bit         dark;
            logic [7:0] s;
            src  = (i - off + ND) % ND;
            dark = r.blank[i] || (r.blink[i] && ph_off);
            s    = {r.dp[i], seg_of(r.data[src*4 +: 4])};
            if (dark) s = 8'h00;
            v[i*SEG +: SEG] = ~s[SEG-1:0];
        end
        return v;
    endfunction

    function automatic bit exp_wrap(input int kq);
        int d;
        d = kq - cur.acc - 1;
        return cur.valid && cur.scroll && (d > 0) && ((d % 48) == 0);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s k=%0d: observed %h expected %h", tag, k, got, exp);
        end
    endtask

    task automatic tick_clk();
        bit acc;
        acc = wr_valid && exp_ready();
        @(posedge clk_clk);
        k++;
        if (acc) begin
            prev       = cur;
            cur.valid  = 1'b1;
            cur.acc    = k;
            cur.data   = wr_data;
            cur.blank  = wr_blank_mask;
            cur.blink  = wr_blink_mask;
            cur.dp     = wr_dp_mask;
            cur.scroll = wr_scroll;
            $display("write k=%0d data=%h blank=%b blink=%b dp=%b scroll=%0d",
                     k, wr_data, wr_blank_mask, wr_blink_mask, wr_dp_mask, wr_scroll);
        end
        @(negedge clk_clk);
        check("ready", 64'(wr_ready), 64'(exp_ready()));
        check("hex", 64'(hex_out), 64'(exp_hex(k)));
        check("wrap", 64'(scroll_wrap), 64'(exp_wrap(k)));
        if (scroll_wrap === 1'b1) wrap_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick_clk();
    endtask

    task automatic do_reset();
        wr_valid    = 1'b0;
        reset_reset = 1'b1;
        #2;
        check("rst_hex", 64'(hex_out), 64'({HW{1'b1}}));
        check("rst_ready", 64'(wr_ready), 64'd1);
        check("rst_wrap", 64'(scroll_wrap), 64'd0);
        @(posedge clk_clk);
        @(negedge clk_clk);
        #1;
        reset_reset = 1'b0;
        k           = 0;
        cur.valid   = 1'b0;
        prev.valid  = 1'b0;
    endtask

    task automatic write(input logic [23:0] d, input logic [5:0] bl, input logic [5:0] bk,
                         input logic [5:0] dp, input bit sc, input int hold);
        wr_data       = d;
        wr_blank_mask = bl;
        wr_blink_mask = bk;
        wr_dp_mask    = dp;
        wr_scroll     = sc;
        wr_valid      = 1'b1;
        run(hold);
        wr_valid      = 1'b0;
    endtask

    initial begin
        logic [6:0] seg5_n;
        logic [6:0] seg0_n;
        int         acc_a;

        seg5_n = ~7'h6D;
        seg0_n = ~7'h3F;

        // Reset, then idle
        #1;
        do_reset();
        run(5);

        // Static decode
        write(24'h012345, 6'b0, 6'b0, 6'b0, 1'b0, 1);
        run(2);
        check("digit0_is_5", 64'(hex_out[6:0]), 64'(seg5_n));
        check("digit5_is_0", 64'(hex_out[SEG*5 +: 7]), 64'(seg0_n));
        run(3);

        // Blink on digit 0
        write(24'h012345, 6'b0, 6'b000001, 6'b000100, 1'b0, 1);
        run(34);

        // Scroll through a full wrap
        write(24'hABCDEF, 6'b0, 6'b0, 6'b0, 1'b1, 1);
        wrap_seen = 0;
        run(52);
        check("wrap_count", 64'(wrap_seen), 64'd1);

        // Write on the edge of a scroll tick, valid held across LOAD with new data
        for (int i = 0; i < 8 && ((k - cur.acc) % 8) != 0; i++) tick_clk();
        wr_data       = 24'h13579B;
        wr_blank_mask = 6'b0;
        wr_blink_mask = 6'b0;
        wr_scroll     = 1'b1;
        wr_valid      = 1'b1;
        tick_clk();
        acc_a   = cur.acc;
        wr_data = 24'h2468AC;
        tick_clk();
        tick_clk();
        wr_valid = 1'b0;
        check("held_write_accepted", 64'(cur.acc - acc_a), 64'd2);
        run(20);

        // Randomized writes
        for (int t = 0; t < 12; t++) begin
            write(24'($urandom), 6'($urandom & $urandom), 6'($urandom), 6'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(1, 3));
            run($urandom_range(3, 60));
        end

        // Reset mid-scroll
        write(24'hFEDCBA, 6'b0, 6'b0, 6'b000100, 1'b1, 1);
        run(20);
        do_reset();
        run(10);

        // Reset during the LOAD cycle: nothing retained
        write(24'h555555, 6'b0, 6'b0, 6'b111111, 1'b0, 1);
        do_reset();
        run(10);

        // Final write after reset to confirm recovery
        write(24'h9876AB, 6'b100000, 6'b000010, 6'b000001, 1'b0, 1);
        run(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
